// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder: PS/2 set-2 scan codes to ASCII through a keymap ROM lookup
//   clk, reset_n          clock, async active-low reset
//   scan_code, scan_valid byte stream from the PS/2 receiver
//   rom_addr, rom_dout    keymap ROM {caps_lock, shift, keycode}; data one clk later
//   ascii, ascii_valid, ascii_ready  decoded character, valid/ready handshake
//   overrun               one-cycle pulse when a byte or character is dropped
module ps2_keyboard_decoder (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [9:0] rom_addr,
   input  logic [7:0] rom_dout,
   output logic [7:0] ascii,
   output logic       ascii_valid,
   input  logic       ascii_ready,
   output logic       overrun
);
   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;
   state_t     state;
   logic       brk, ext, lshift, rshift, caps_lock, caps_down;
   logic [2:0] skip_cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         brk         <= 1'b0;
         ext         <= 1'b0;
         lshift      <= 1'b0;
         rshift      <= 1'b0;
         caps_lock   <= 1'b0;
         caps_down   <= 1'b0;
         skip_cnt    <= 3'd0;
         rom_addr    <= 10'd0;
         ascii       <= 8'd0;
         ascii_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (ascii_valid && ascii_ready) ascii_valid <= 1'b0;
         case (state)
            IDLE: if (scan_valid) begin
               if (skip_cnt != 3'd0) skip_cnt <= skip_cnt - 3'd1;
               else if (scan_code == 8'hE1) skip_cnt <= 3'd7;
               else if (scan_code == 8'hE0) ext <= 1'b1;
               else if (scan_code == 8'hF0) brk <= 1'b1;
               else begin
                  ext <= 1'b0;
                  brk <= 1'b0;
                  if (brk) begin
                     if (!ext) begin
                        if (scan_code == 8'h12) lshift <= 1'b0;
                        if (scan_code == 8'h59) rshift <= 1'b0;
                        if (scan_code == 8'h58) caps_down <= 1'b0;
                     end
                  end else if (!ext && (scan_code == 8'h12 || scan_code == 8'h59 || scan_code == 8'h58)) begin
                     if (scan_code == 8'h12) lshift <= 1'b1;
                     if (scan_code == 8'h59) rshift <= 1'b1;
                     if (scan_code == 8'h58) begin
                        caps_down <= 1'b1;
                        // typematic repeats keep caps_down set and must not toggle again
                        if (!caps_down) caps_lock <= !caps_lock;
                     end
                  end else begin
                     rom_addr <= {caps_lock, lshift | rshift, ext ? {1'b1, scan_code[6:0]} : scan_code};
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               overrun <= scan_valid;
               state   <= CAPTURE;
            end
            default: begin
               overrun <= scan_valid;
               state   <= IDLE;
               if (rom_dout != 8'd0) begin
                  if (!ascii_valid || ascii_ready) begin
                     ascii       <= rom_dout;
                     ascii_valid <= 1'b1;
                  end else overrun <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// tb_ps2_keyboard_decoder: directed scan sequences against a queued expected-character scoreboard
module tb_ps2_keyboard_decoder;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] scan_code = 8'd0;
   logic       scan_valid = 1'b0;
   logic [9:0] rom_addr;
   logic [7:0] rom_dout;
   logic [7:0] ascii;
   logic       ascii_valid;
   logic       ascii_ready = 1'b1;
   logic       overrun;
   logic [7:0] rom [0:1023];
   logic [7:0] exp_q [$];
   logic [7:0] exp_ch;
   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
   int         checks = 0;
   int         errors = 0;
   int         ov_cnt = 0;
   int         ov0;
   ps2_keyboard_decoder dut (
      .clk(clk), .reset_n(reset_n), .scan_code(scan_code), .scan_valid(scan_valid),
      .rom_addr(rom_addr), .rom_dout(rom_dout), .ascii(ascii), .ascii_valid(ascii_valid),
      .ascii_ready(ascii_ready), .overrun(overrun)
   );
   always #5 clk = ~clk;
   always @(posedge clk) rom_dout <= rom[rom_addr];
   always @(negedge clk) begin
      #2;
      if (reset_n) begin
         if (overrun) ov_cnt++;
         if (ascii_valid && ascii_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_char: got %h, expected no character", ascii);
            end else begin
               exp_ch = exp_q.pop_front();
               if (ascii !== exp_ch) begin
                  errors++;
                  $display("FAIL ascii: got %h, expected %h", ascii, exp_ch);
               end
            end
         end
      end
   end
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic send(input logic [7:0] c);
      @(negedge clk);
      scan_code = c;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      rom[10'h01C] = 8'h61;
      rom[10'h11C] = 8'h41;
      rom[10'h21C] = 8'h41;
      rom[10'h31C] = 8'h61;
      rom[10'h0F5] = 8'h1B;
      repeat (3) @(negedge clk);
      chk("rst_rom_addr", 16'(rom_addr), 16'h000);
      chk("rst_ascii", 16'(ascii), 16'h00);
      chk("rst_valid", 16'(ascii_valid), 16'h0);
      chk("rst_overrun", 16'(overrun), 16'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      // latency: sample edge 0, ascii_valid at edge 2
      exp_q.push_back(8'h61);
      scan_code = 8'h1C;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      chk("lat_rom_addr", 16'(rom_addr), 16'h01C);
      chk("lat_valid_e0", 16'(ascii_valid), 16'h0);
      @(negedge clk);
      chk("lat_valid_e1", 16'(ascii_valid), 16'h0);
      @(negedge clk);
      chk("lat_valid_e2", 16'(ascii_valid), 16'h1);
      chk("lat_ascii_e2", 16'(ascii), 16'h61);
      repeat (3) @(negedge clk);
      // shift make/break
      send(8'h12);
      exp_q.push_back(8'h41);
      send(8'h1C);
      chk("shift_addr", 16'(rom_addr), 16'h11C);
      send(8'hF0);
      send(8'h1C);
      chk("break_hold_addr", 16'(rom_addr), 16'h11C);
      send(8'hF0);
      send(8'h12);
      exp_q.push_back(8'h61);
      send(8'h1C);
      chk("unshift_addr", 16'(rom_addr), 16'h01C);
      // caps lock with typematic repeat
      send(8'h58);
      send(8'h58);
      send(8'hF0);
      send(8'h58);
      exp_q.push_back(8'h41);
      send(8'h1C);
      chk("caps_addr", 16'(rom_addr), 16'h21C);
      send(8'h58);
      exp_q.push_back(8'h61);
      send(8'h1C);
      chk("caps_off_addr", 16'(rom_addr), 16'h01C);
      send(8'hF0);
      send(8'h58);
      // extended codes
      send(8'hE0);
      exp_q.push_back(8'h1B);
      send(8'h75);
      chk("ext_addr", 16'(rom_addr), 16'h0F5);
      send(8'hE0);
      send(8'h12);
      chk("ext12_addr", 16'(rom_addr), 16'h092);
      send(8'hE0);
      send(8'hF0);
      send(8'h12);
      exp_q.push_back(8'h61);
      send(8'h1C);
      chk("ext_noshift_addr", 16'(rom_addr), 16'h01C);
      // zero ROM entry, then pause sequence
      send(8'h15);
      chk("zero_addr", 16'(rom_addr), 16'h015);
      foreach (pause_seq[i]) send(pause_seq[i]);
      chk("pause_addr", 16'(rom_addr), 16'h015);
      exp_q.push_back(8'h61);
      send(8'h1C);
      chk("post_pause_addr", 16'(rom_addr), 16'h01C);
      // held character, second dropped
      ascii_ready = 1'b0;
      ov0 = ov_cnt;
      exp_q.push_back(8'h61);
      send(8'h1C);
      chk("hold_valid", 16'(ascii_valid), 16'h1);
      chk("hold_ascii", 16'(ascii), 16'h61);
      chk("hold_no_ovr", 16'(ov_cnt), 16'(ov0));
      send(8'h12);
      exp_q.push_back(8'h41);
      send(8'h1C);
      chk("drop_ovr", 16'(ov_cnt), 16'(ov0 + 1));
      chk("drop_keeps_ascii", 16'(ascii), 16'h61);
      chk("drop_keeps_valid", 16'(ascii_valid), 16'h1);
      void'(exp_q.pop_back());
      @(negedge clk);
      ascii_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("hold_drained", 16'(exp_q.size()), 16'd0);
      // reset during WAIT
      scan_code = 8'h1C;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midrst_rom_addr", 16'(rom_addr), 16'h000);
      chk("midrst_ascii", 16'(ascii), 16'h00);
      chk("midrst_valid", 16'(ascii_valid), 16'h0);
      chk("midrst_overrun", 16'(overrun), 16'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      // byte arriving during WAIT
      ov0 = ov_cnt;
      exp_q.push_back(8'h61);
      @(negedge clk);
      scan_code = 8'h1C;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_code = 8'h15;
      @(negedge clk);
      scan_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("wait_byte_ovr", 16'(ov_cnt), 16'(ov0 + 1));
      chk("wait_byte_addr", 16'(rom_addr), 16'h01C);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
